// File: rtl/ge_tobytes_seq.sv
// ge_tobytes_seq: Ed25519 point encoder. Inverts Z as Z^(p-2) on a shared external field
// multiplier, then reduces y = Y/Z and x = X/Z to canonical form and packs the 32-byte encoding.
module ge_tobytes_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   input  logic [319:0] h_x,
   input  logic [319:0] h_y,
   input  logic [319:0] h_z,
   output logic [255:0] s,
   output logic         done,
   output logic [319:0] mul_op_a,
   output logic [319:0] mul_op_b,
   output logic         mul_valid,
   input  logic [319:0] mul_res,
   input  logic         mul_done
);
   localparam int FE_W = 320;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INV_SQ  = 3'd1,
      INV_MUL = 3'd2,
      MUL_X   = 3'd3,
      MUL_Y   = 3'd4,
      PACK1   = 3'd5,
      PACK2   = 3'd6
   } state_t;

   state_t             state;
   logic               wait_mul;
   logic [7:0]         bit_idx;
   logic [FE_W-1:0]    x_in;
   logic [FE_W-1:0]    y_in;
   logic [FE_W-1:0]    z_in;
   logic [FE_W-1:0]    acc;
   logic [FE_W-1:0]    x_p0;
   logic [FE_W-1:0]    y_p0;
   logic signed [63:0] q_x_p1;
   logic signed [63:0] q_y_p1;
   logic [254:0]       x_can;
   logic [254:0]       y_can;
   logic [FE_W-1:0]    op_a;
   logic [FE_W-1:0]    op_b;

   function automatic logic signed [63:0] limb(input logic [FE_W-1:0] h, input int i);
      return {{32{h[32*i+31]}}, h[32*i +: 32]};
   endfunction

   // Bit i of the inversion exponent p-2 = 2^255-21; only bits 4 and 2 are clear below 255.
   function automatic logic exp_bit(input logic [7:0] i);
      logic r;
      case (i)
         8'd4, 8'd2: r = 1'b0;
         default:    r = 1'b1;
      endcase
      return r;
   endfunction

   // Quotient of h by p (0 or 1 for reduced-range limbs), found by rippling the rounding carry.
   function automatic logic signed [63:0] calc_q(input logic [FE_W-1:0] h);
      logic signed [63:0] q;
      q = (64'sd19 * limb(h, 9) + 64'sd16777216) >>> 25;
      for (int i = 0; i < 10; i++)
         q = (limb(h, i) + q) >>> (i[0] ? 25 : 26);
      return q;
   endfunction

   function automatic logic [254:0] canon(input logic [FE_W-1:0] h, input logic signed [63:0] q);
      logic signed [63:0] t [10];
      logic signed [63:0] c;
      logic [254:0]       r;
      int                 pos;
      for (int i = 0; i < 10; i++)
         t[i] = limb(h, i);
      t[0] = t[0] + 64'sd19 * q;
      for (int i = 0; i < 9; i++) begin
         c      = t[i] >>> (i[0] ? 25 : 26);
         t[i+1] = t[i+1] + c;
         t[i]   = t[i] - (c <<< (i[0] ? 25 : 26));
      end
      // Keeping only 25 bits of limb 9 drops the 2^255 multiple, finishing the subtraction of q*p.
      r   = '0;
      pos = 0;
      for (int i = 0; i < 10; i++) begin
         if (i[0]) begin
            r[pos +: 25] = t[i][24:0];
            pos += 25;
         end else begin
            r[pos +: 26] = t[i][25:0];
            pos += 26;
         end
      end
      return r;
   endfunction

   always_comb begin
      op_a = acc;
      op_b = acc;
      case (state)
         INV_MUL: op_b = z_in;
         MUL_X:   op_a = x_in;
         MUL_Y:   op_a = y_in;
         default: ;
      endcase
   end

   assign x_can = canon(x_p0, q_x_p1);
   assign y_can = canon(y_p0, q_y_p1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_mul  <= 1'b0;
         bit_idx   <= 8'd0;
         s         <= '0;
         done      <= 1'b0;
         mul_valid <= 1'b0;
         mul_op_a  <= '0;
         mul_op_b  <= '0;
      end else begin
         done      <= 1'b0;
         mul_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (valid) begin
                  x_in     <= h_x;
                  y_in     <= h_y;
                  z_in     <= h_z;
                  acc      <= h_z;
                  bit_idx  <= 8'd253;
                  wait_mul <= 1'b0;
                  state    <= INV_SQ;
               end
            end
            INV_SQ, INV_MUL, MUL_X, MUL_Y: begin
               if (!wait_mul) begin
                  mul_op_a  <= op_a;
                  mul_op_b  <= op_b;
                  mul_valid <= 1'b1;
                  wait_mul  <= 1'b1;
               end else if (mul_done) begin
                  wait_mul <= 1'b0;
                  if (state == INV_SQ) begin
                     acc <= mul_res;
                     if (exp_bit(bit_idx))
                        state <= INV_MUL;
                     else if (bit_idx == 8'd0)
                        state <= MUL_X;
                     else
                        bit_idx <= bit_idx - 8'd1;
                  end else if (state == INV_MUL) begin
                     acc <= mul_res;
                     if (bit_idx == 8'd0) begin
                        state <= MUL_X;
                     end else begin
                        bit_idx <= bit_idx - 8'd1;
                        state   <= INV_SQ;
                     end
                  end else if (state == MUL_X) begin
                     x_p0  <= mul_res;
                     state <= MUL_Y;
                  end else begin
                     y_p0  <= mul_res;
                     state <= PACK1;
                  end
               end
            end
            // pack stage 1: quotient by p for both coordinates
            PACK1: begin
               q_x_p1 <= calc_q(x_p0);
               q_y_p1 <= calc_q(y_p0);
               state  <= PACK2;
            end
            // pack stage 2: canonical reduction and byte packing
            PACK2: begin
               s     <= {x_can[0], y_can};
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
